vx_commit_arbiter: RTL
======================

// Module: vx_commit_arbiter
// PURPOSE
//  Merges the commit streams of the execute units (ALU, LSU, SFU, FPU) for one issue slot
//  into a single registered writeback/commit stream for the register-file writeback stage.
//  Uses round-robin arbitration among units. A multi-packet commit (sop..eop) holds the grant
//  until its eop beat, so packets from different units never interleave.
//  Also counts retired commits (eop beats) for perf counters.
// PARAMETERS
//  NUM_INPUTS  4   number of execute-unit commit streams (>=2)
//  DATAW       64  width of opaque commit payload per stream
//  CNT_W       32  width of retired-commit counter
// PORTS
//  clk           in   1                 clock
//  reset         in   1                 asynchronous, active-high reset
//  in_valid      in   NUM_INPUTS        per-unit commit valid
//  in_data       in   NUM_INPUTS*DATAW  per-unit payload; unit i at [i*DATAW +: DATAW]
//  in_sop        in   NUM_INPUTS        per-unit start-of-packet flag
//  in_eop        in   NUM_INPUTS        per-unit end-of-packet flag
//  in_ready      out  NUM_INPUTS        per-unit accept
//  out_valid     out  1                 merged commit valid
//  out_data      out  DATAW             merged payload
//  out_sop       out  1                 merged start-of-packet flag
//  out_eop       out  1                 merged end-of-packet flag
//  out_src       out  $clog2(NUM_INPUTS)  index of the source unit for the current out beat
//  out_ready     in   1                 downstream accept
//  commit_count  out  CNT_W             number of eop beats transferred on out_*
// BEHAVIOUR
//  Reset (async, active-high): all outputs 0; rr_ptr=0; locked=0; lock_idx=0; commit_count=0.
//    Reset asserted mid-packet drops the partial packet. No beat is produced after release
//    until new input arrives.
//  Output stage: one register. load_en = !out_valid || out_ready.
//    Latency: exactly 1 cycle from in handshake to out_valid.
//  Grant when unlocked: scan inputs starting at rr_ptr, wrapping modulo NUM_INPUTS.
//    The first input with in_valid=1 wins.
//  Grant when locked: only lock_idx may be granted, even if other inputs are valid.
//  in_ready[i] = load_en && (grant==i) && in_valid[i]; all other bits are 0.
//    in_ready is combinational from out_ready; there is no combinational in_valid->out path.
//  Transfer on unit g (in_valid[g] && in_ready[g]):
//    register in_data/sop/eop of g into out_*; out_src<=g; out_valid<=1.
//    If eop=0: locked<=1, lock_idx<=g.
//    If eop=1: locked<=0, rr_ptr <= (g+1) mod NUM_INPUTS.
//  No transfer while load_en=1: out_valid<=0.
//  While load_en=0: out_* hold stable (standard valid/ready rule); state does not change.
//  A sop=1 beat arriving while locked on the same unit (protocol error):
//    accept it as a new packet start; the lock persists until eop.
//  Single-beat packets have sop=eop=1.
//  commit_count increments by 1 on each out_valid && out_ready && out_eop; wraps at 2^CNT_W.
//  Downstream eop handshake and upstream handshake in the same cycle: both take effect.
//    The counter counts the outgoing beat; the register loads the incoming beat.
//  rr_ptr changes only on eop transfers, never on non-eop beats or idle cycles.
// TESTING
//  1. Reset: reset=1 with inputs toggling -> all outputs 0, in_ready=0, commit_count=0.
//  2. Fairness: all 4 inputs valid, single-beat, out_ready=1 -> out_src sequence 0,1,2,3,0,...
//     One beat per cycle; commit_count=8 after 8 beats.
//  3. Packet lock: unit1 sends 3 beats (sop,-,eop) while units 0,2 are valid ->
//     out_src=1 for 3 consecutive beats, then 2, then 3-or-0 by rr order.
//     commit_count increments only once for the packet.
//  4. Backpressure: out_ready=0 for 5 cycles with out_valid=1 ->
//     out_data stable and in_ready=0 throughout; resumes with the next granted beat.
//  5. Simultaneous: out_ready=1 and new in transfer each cycle -> 100% throughput, no bubbles.
//     Data matches the input stream in order.
//  6. Reset mid-packet: assert reset after unit2 sop beat -> locked cleared.
//     After release, unit0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter - round-robin merge of execute-unit commit streams into one registered commit stream
// Packets (sop..eop) hold the grant until eop; eop beats leaving the output are counted.
module vx_commit_arbiter #(
   parameter  int NUM_INPUTS = 4,
   parameter  int DATAW      = 64,
   parameter  int CNT_W      = 32,
   localparam int SRC_W      = $clog2(NUM_INPUTS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_INPUTS-1:0]       in_valid,
   input  logic [NUM_INPUTS*DATAW-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]       in_sop,
   input  logic [NUM_INPUTS-1:0]       in_eop,
   output logic [NUM_INPUTS-1:0]       in_ready,
   output logic                        out_valid,
   output logic [DATAW-1:0]            out_data,
   output logic                        out_sop,
   output logic                        out_eop,
   output logic [SRC_W-1:0]            out_src,
   input  logic                        out_ready,
   output logic [CNT_W-1:0]            commit_count
);

   logic             load_en;
   logic [SRC_W-1:0] rr_ptr;
   logic             locked;
   logic [SRC_W-1:0] lock_idx;
   logic [SRC_W-1:0] grant;
   logic             grant_valid;
   logic [SRC_W:0]   cand;
   logic [SRC_W-1:0] rr_next;

   assign load_en = !out_valid || out_ready;
   assign rr_next = (grant == SRC_W'(NUM_INPUTS - 1)) ? '0 : grant + SRC_W'(1);

   // While a packet is open only its unit may be granted; otherwise scan from rr_ptr with wrap.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      cand        = '0;
      if (locked) begin
         grant       = lock_idx;
         grant_valid = in_valid[lock_idx];
      end else begin
         for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_INPUTS))
               cand = cand - (SRC_W+1)'(NUM_INPUTS);
            if (!grant_valid && in_valid[cand[SRC_W-1:0]]) begin
               grant       = cand[SRC_W-1:0];
               grant_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (!reset && load_en && grant_valid)
         in_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sop      <= 1'b0;
         out_eop      <= 1'b0;
         out_src      <= '0;
         commit_count <= '0;
         rr_ptr       <= '0;
         locked       <= 1'b0;
         lock_idx     <= '0;
      end else begin
         // Counts the beat leaving the output; independent of what loads this cycle.
         if (out_valid && out_ready && out_eop)
            commit_count <= commit_count + CNT_W'(1);
         if (load_en) begin
            if (grant_valid) begin
               out_valid <= 1'b1;
               out_data  <= in_data[grant*DATAW +: DATAW];
               out_sop   <= in_sop[grant];
               out_eop   <= in_eop[grant];
               out_src   <= grant;
               if (in_eop[grant]) begin
                  locked <= 1'b0;
                  rr_ptr <= rr_next;
               end else begin
                  locked   <= 1'b1;
                  lock_idx <= grant;
               end
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
